// File: rtl/ram_arbiter.sv
// Round-robin arbiter between instruction fetch (I) and load/store (D) in front of a
// single-port burst ram; each request becomes one single-beat ram transaction.
module ram_arbiter #(
    parameter int AWIDTH  = 32,
    parameter int DWIDTH  = 32,
    parameter int LWIDTH  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [AWIDTH-1:0] i_addr,
    output logic              i_accept,
    output logic              i_rvalid,
    output logic [DWIDTH-1:0] i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [AWIDTH-1:0] d_addr,
    input  logic [DWIDTH-1:0] d_wdata,
    output logic              d_accept,
    output logic              d_done,
    output logic [DWIDTH-1:0] d_rdata,
    output logic              d_err,
    output logic [AWIDTH-1:0] awaddr,
    output logic [LWIDTH-1:0] awlen,
    output logic              awvalid,
    input  logic              awready,
    output logic [DWIDTH-1:0] wdata,
    output logic              wready,
    input  logic              wvalid,
    input  logic              wlast,
    output logic [AWIDTH-1:0] araddr,
    output logic [LWIDTH-1:0] arlen,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DWIDTH-1:0] rdata,
    input  logic              rvalid,
    input  logic              rlast,
    output logic              rready
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ADDR  = 2'd1;
    localparam logic [1:0] S_WDATA = 2'd2;
    localparam logic [1:0] S_RDATA = 2'd3;

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit WD_EN = (TIMEOUT > 0);

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              last_d_q, last_d_d;
    logic              owner_d_q, owner_d_d;
    logic              we_q, we_d;
    logic              i_accept_q, i_accept_d, i_rvalid_q, i_rvalid_d, i_err_q, i_err_d;
    logic              d_accept_q, d_accept_d, d_done_q, d_done_d, d_err_q, d_err_d;
    logic [DWIDTH-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d, wdata_q, wdata_d;
    logic [AWIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [LWIDTH-1:0] len_q, len_d;
    logic              awvalid_q, awvalid_d, arvalid_q, arvalid_d;
    logic              wready_q, wready_d, rready_q, rready_d;
    logic              grant_i_s, grant_d_s, timeout_s, abort_s;

    // rvalid and wvalid carry no information here: rlast/wlast alone end a beat.
    logic unused_ok;
    assign unused_ok = wvalid ^ rvalid;

    assign timeout_s = WD_EN && (cnt_q == CNT_LAST);

    // Next-state, grant, watchdog and output computation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d_d   = last_d_q;
        owner_d_d  = owner_d_q;
        we_d       = we_q;
        i_accept_d = 1'b0;
        i_rvalid_d = 1'b0;
        i_err_d    = 1'b0;
        d_accept_d = 1'b0;
        d_done_d   = 1'b0;
        d_err_d    = 1'b0;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        wdata_d    = wdata_q;
        awaddr_d   = awaddr_q;
        araddr_d   = araddr_q;
        len_d      = LWIDTH'(1);
        awvalid_d  = awvalid_q;
        arvalid_d  = arvalid_q;
        wready_d   = wready_q;
        rready_d   = rready_q;
        grant_i_s  = 1'b0;
        grant_d_s  = 1'b0;
        abort_s    = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d     = '0;
                grant_i_s = i_req && (!d_req || last_d_q);
                grant_d_s = d_req && !grant_i_s;
                if (grant_i_s) begin
                    i_accept_d = 1'b1;
                    last_d_d   = 1'b0;
                    owner_d_d  = 1'b0;
                    we_d       = 1'b0;
                    araddr_d   = i_addr;
                    arvalid_d  = 1'b1;
                    state_d    = S_ADDR;
                end else if (grant_d_s) begin
                    d_accept_d = 1'b1;
                    last_d_d   = 1'b1;
                    owner_d_d  = 1'b1;
                    we_d       = d_we;
                    state_d    = S_ADDR;
                    if (d_we) begin
                        awaddr_d  = d_addr;
                        wdata_d   = d_wdata;
                        awvalid_d = 1'b1;
                    end else begin
                        araddr_d  = d_addr;
                        arvalid_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADDR: begin
                cnt_d = cnt_q + CW'(1);
                if ((awvalid_q && awready) || (arvalid_q && arready)) begin
                    awvalid_d = 1'b0;
                    arvalid_d = 1'b0;
                    wready_d  = we_q;
                    rready_d  = !we_q;
                    state_d   = we_q ? S_WDATA : S_RDATA;
                end else if (timeout_s) begin
                    abort_s = 1'b1;
                end else begin
                    state_d = S_ADDR;
                end
            end
            S_WDATA: begin
                cnt_d = cnt_q + CW'(1);
                if (wlast) begin
                    wready_d = 1'b0;
                    d_done_d = 1'b1;
                    state_d  = S_IDLE;
                end else if (timeout_s) begin
                    abort_s = 1'b1;
                end else begin
                    state_d = S_WDATA;
                end
            end
            S_RDATA: begin
                cnt_d = cnt_q + CW'(1);
                if (rlast) begin
                    rready_d = 1'b0;
                    state_d  = S_IDLE;
                    if (owner_d_q) begin
                        d_rdata_d = rdata;
                        d_done_d  = 1'b1;
                    end else begin
                        i_rdata_d  = rdata;
                        i_rvalid_d = 1'b1;
                    end
                end else if (timeout_s) begin
                    abort_s = 1'b1;
                end else begin
                    state_d = S_RDATA;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // A stalled transaction is dropped silently on the ram side and reported to its owner.
        if (abort_s) begin
            awvalid_d = 1'b0;
            arvalid_d = 1'b0;
            wready_d  = 1'b0;
            rready_d  = 1'b0;
            i_err_d   = !owner_d_q;
            d_err_d   = owner_d_q;
            state_d   = S_IDLE;
        end else begin
            state_d = state_d;
        end
    end

    // State and output registers; last grant resets to D so I wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            last_d_q   <= 1'b1;
            owner_d_q  <= 1'b0;
            we_q       <= 1'b0;
            i_accept_q <= 1'b0;
            i_rvalid_q <= 1'b0;
            i_err_q    <= 1'b0;
            d_accept_q <= 1'b0;
            d_done_q   <= 1'b0;
            d_err_q    <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            wdata_q    <= '0;
            awaddr_q   <= '0;
            araddr_q   <= '0;
            len_q      <= '0;
            awvalid_q  <= 1'b0;
            arvalid_q  <= 1'b0;
            wready_q   <= 1'b0;
            rready_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_d_q   <= last_d_d;
            owner_d_q  <= owner_d_d;
            we_q       <= we_d;
            i_accept_q <= i_accept_d;
            i_rvalid_q <= i_rvalid_d;
            i_err_q    <= i_err_d;
            d_accept_q <= d_accept_d;
            d_done_q   <= d_done_d;
            d_err_q    <= d_err_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
            wdata_q    <= wdata_d;
            awaddr_q   <= awaddr_d;
            araddr_q   <= araddr_d;
            len_q      <= len_d;
            awvalid_q  <= awvalid_d;
            arvalid_q  <= arvalid_d;
            wready_q   <= wready_d;
            rready_q   <= rready_d;
        end
    end

    assign i_accept = i_accept_q;
    assign i_rvalid = i_rvalid_q;
    assign i_rdata  = i_rdata_q;
    assign i_err    = i_err_q;
    assign d_accept = d_accept_q;
    assign d_done   = d_done_q;
    assign d_rdata  = d_rdata_q;
    assign d_err    = d_err_q;
    assign awaddr   = awaddr_q;
    assign awlen    = len_q;
    assign awvalid  = awvalid_q;
    assign wdata    = wdata_q;
    assign wready   = wready_q;
    assign araddr   = araddr_q;
    assign arlen    = len_q;
    assign arvalid  = arvalid_q;
    assign rready   = rready_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: ram stub, timeline-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_ram_arbiter;

    localparam int TO = 8;

    logic        clk, rst;
    logic        i_req, i_accept, i_rvalid, i_err;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_accept, d_done, d_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic        awvalid, awready, wready, wvalid, wlast;
    logic        arvalid, arready, rvalid, rlast, rready;
    logic        stall_aw;

    int n_chk = 0;
    int n_err = 0;

    ram_arbiter #(.AWIDTH(32), .DWIDTH(32), .LWIDTH(8), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_accept(i_accept), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_accept(d_accept), .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
        .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wready(wready), .wvalid(wvalid), .wlast(wlast),
        .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- ram stub: one-beat responses, one cycle after handshake ----------
    logic [31:0] ram_mem [0:63];
    logic        wphase, wlast_r, rpend, rlast_r;
    logic [31:0] rdata_r;
    logic [5:0]  w_idx, r_idx;

    assign awready = !stall_aw;
    assign arready = 1'b1;
    assign wvalid  = wlast_r;
    assign wlast   = wlast_r;
    assign rvalid  = rlast_r;
    assign rlast   = rlast_r;
    assign rdata   = rdata_r;

    always @(posedge clk) begin
        if (rst) begin
            wphase <= 1'b0; wlast_r <= 1'b0; rpend <= 1'b0; rlast_r <= 1'b0; rdata_r <= 32'd0;
        end else begin
            if (awvalid && awready) begin wphase <= 1'b1; w_idx <= awaddr[7:2]; end
            if (wphase && wready && !wlast_r) begin
                ram_mem[w_idx] <= wdata; wlast_r <= 1'b1;
            end else if (wlast_r) begin
                wlast_r <= 1'b0; wphase <= 1'b0;
            end
            if (arvalid && arready) begin rpend <= 1'b1; r_idx <= araddr[7:2]; end
            if (rpend && rready && !rlast_r) begin
                rdata_r <= ram_mem[r_idx]; rlast_r <= 1'b1;
            end else if (rlast_r) begin
                rlast_r <= 1'b0; rpend <= 1'b0;
            end
        end
    end

    // ---------------- reference model: each transaction follows a fixed timeline -------
    // accept at age 0; completion at age 3; a stalled write errors at age TO.
    logic [31:0] model_mem [0:63];
    bit          started = 1'b0;
    bit          m_busy, m_owner_d, m_we, m_stall, m_last_d;
    int          m_age;
    logic [31:0] m_addr, m_wdata;
    logic        e_i_accept, e_d_accept, e_i_rvalid, e_d_done, e_i_err, e_d_err;
    logic        e_awvalid, e_arvalid, e_wready, e_rready;
    logic [31:0] e_i_rdata, e_d_rdata;
    logic [7:0]  e_len;

    task automatic model_step();
        e_i_accept = 1'b0; e_d_accept = 1'b0; e_i_rvalid = 1'b0;
        e_d_done = 1'b0; e_i_err = 1'b0; e_d_err = 1'b0;
        if (rst) begin
            m_busy = 1'b0; m_last_d = 1'b1; m_age = 0;
            e_i_rdata = 32'd0; e_d_rdata = 32'd0; e_len = 8'd0;
        end else begin
            e_len = 8'd1;
            if (m_busy) begin
                m_age++;
                if (m_stall && m_age == TO) begin
                    m_busy = 1'b0;
                    if (m_owner_d) e_d_err = 1'b1; else e_i_err = 1'b1;
                end else if (!m_stall && m_age == 3) begin
                    m_busy = 1'b0;
                    if (m_we) begin
                        model_mem[m_addr[7:2]] = m_wdata; e_d_done = 1'b1;
                    end else if (m_owner_d) begin
                        e_d_rdata = model_mem[m_addr[7:2]]; e_d_done = 1'b1;
                    end else begin
                        e_i_rdata = model_mem[m_addr[7:2]]; e_i_rvalid = 1'b1;
                    end
                end
            end else if (i_req || d_req) begin
                m_owner_d = !(i_req && (!d_req || m_last_d));
                m_last_d  = m_owner_d;
                m_busy = 1'b1; m_age = 0;
                if (m_owner_d) begin
                    m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; e_d_accept = 1'b1;
                end else begin
                    m_we = 1'b0; m_addr = i_addr; e_i_accept = 1'b1;
                end
                m_stall = m_we && stall_aw;
            end
        end
        e_awvalid = m_busy && m_we && (m_age == 0 || m_stall);
        e_arvalid = m_busy && !m_we && m_age == 0;
        e_wready  = m_busy && m_we && !m_stall && m_age >= 1;
        e_rready  = m_busy && !m_we && m_age >= 1;
        started = 1'b1;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    int acc_total = 0;
    int fin_total = 0;

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            chk("aw_ar_excl", {31'd0, awvalid & arvalid}, 32'd0);
            chk("i_accept", {31'd0, i_accept}, {31'd0, e_i_accept});
            chk("d_accept", {31'd0, d_accept}, {31'd0, e_d_accept});
            chk("i_rvalid", {31'd0, i_rvalid}, {31'd0, e_i_rvalid});
            chk("d_done", {31'd0, d_done}, {31'd0, e_d_done});
            chk("i_err", {31'd0, i_err}, {31'd0, e_i_err});
            chk("d_err", {31'd0, d_err}, {31'd0, e_d_err});
            chk("awvalid", {31'd0, awvalid}, {31'd0, e_awvalid});
            chk("arvalid", {31'd0, arvalid}, {31'd0, e_arvalid});
            chk("wready", {31'd0, wready}, {31'd0, e_wready});
            chk("rready", {31'd0, rready}, {31'd0, e_rready});
            chk("i_rdata", i_rdata, e_i_rdata);
            chk("d_rdata", d_rdata, e_d_rdata);
            chk("awlen", {24'd0, awlen}, {24'd0, e_len});
            chk("arlen", {24'd0, arlen}, {24'd0, e_len});
            if (e_awvalid) chk("awaddr", awaddr, m_addr);
            if (e_arvalid) chk("araddr", araddr, m_addr);
            if (e_wready) chk("wdata", wdata, m_wdata);
            acc_total += int'(i_accept) + int'(d_accept);
            fin_total += int'(i_rvalid) + int'(d_done) + int'(i_err) + int'(d_err);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_flags"}, {22'd0, i_accept, i_rvalid, i_err, d_accept, d_done, d_err,
                             awvalid, arvalid, wready, rready}, 32'd0);
        chk({nm, "_i_rdata"}, i_rdata, 32'd0);
        chk({nm, "_d_rdata"}, d_rdata, 32'd0);
        chk({nm, "_addr_len"}, awaddr | araddr | wdata | {24'd0, awlen | arlen}, 32'd0);
    endtask

    task automatic run_i(input logic [31:0] a, output int acc_c, output int fin_c);
        i_req = 1'b1; i_addr = a; acc_c = -1; fin_c = -1;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (i_accept) begin acc_c = n; i_req = 1'b0; end
            if (i_rvalid || i_err) begin fin_c = n; break; end
        end
        i_req = 1'b0;
        chk("i_txn_bound", {31'd0, fin_c > 0}, 32'd1);
    endtask

    task automatic run_d(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         output int acc_c, output int fin_c, output bit was_err);
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
        acc_c = -1; fin_c = -1; was_err = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (d_accept) begin acc_c = n; d_req = 1'b0; end
            if (d_done || d_err) begin fin_c = n; was_err = d_err; break; end
        end
        d_req = 1'b0;
        chk("d_txn_bound", {31'd0, fin_c > 0}, 32'd1);
    endtask

    int acc_c, fin_c, k, aw_cnt;
    bit was_err;
    logic [5:0] seq;

    initial begin
        for (int i = 0; i < 64; i++) begin ram_mem[i] = 32'd0; model_mem[i] = 32'd0; end
        ram_mem[4] = 32'hDEADBEEF; model_mem[4] = 32'hDEADBEEF;
        rst = 1'b1; stall_aw = 1'b0;
        i_req = 1'b0; i_addr = 32'd0; d_req = 1'b0; d_we = 1'b0;
        d_addr = 32'd0; d_wdata = 32'd0;
        step(); step(); step();
        chk_all_zero("reset");
        rst = 1'b0;
        step();

        // I read of 0x10 alone.
        run_i(32'h10, acc_c, fin_c);
        chk("i_read_accept_cycle", acc_c, 32'd1);
        chk("i_read_done_cycle", fin_c, 32'd4);
        chk("i_read_data", i_rdata, 32'hDEADBEEF);
        step();

        // D write then D read back.
        run_d(1'b1, 32'h20, 32'h12345678, acc_c, fin_c, was_err);
        chk("d_write_done_cycle", fin_c, 32'd4);
        chk("d_write_not_err", {31'd0, was_err}, 32'd0);
        step();
        run_d(1'b0, 32'h20, 32'h0, acc_c, fin_c, was_err);
        chk("d_read_done_cycle", fin_c, 32'd4);
        chk("d_read_data", d_rdata, 32'h12345678);
        step();

        // Continuous contention after a reset: grants must alternate starting with I.
        rst = 1'b1; step(); rst = 1'b0;
        i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        k = 0; seq = 6'd0;
        for (int n = 0; n < 60 && k < 6; n++) begin
            step();
            if (i_accept || d_accept) begin seq[k] = d_accept; k++; end
        end
        i_req = 1'b0; d_req = 1'b0;
        chk("contention_grants", k, 32'd6);
        chk("contention_order", {26'd0, seq}, 32'h2A);
        for (int n = 0; n < 10 && !d_done; n++) step();
        chk("contention_last_data", d_rdata, 32'h12345678);
        step();

        // Stalled write address channel: watchdog abort.
        stall_aw = 1'b1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_wdata = 32'hA5A5A5A5;
        aw_cnt = 0; fin_c = -1; was_err = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            step();
            if (d_accept) d_req = 1'b0;
            if (awvalid) aw_cnt++;
            if (d_err || d_done) begin fin_c = n; was_err = d_err; break; end
        end
        d_req = 1'b0;
        chk("stall_awvalid_cycles", aw_cnt, 32'd8);
        chk("stall_err_cycle", fin_c, 32'd9);
        chk("stall_is_err", {31'd0, was_err}, 32'd1);
        chk("stall_awvalid_dropped", {31'd0, awvalid}, 32'd0);
        stall_aw = 1'b0;
        step();

        // Reset during the write-data phase, then a fresh transaction.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h55AA55AA;
        for (int n = 0; n < 10 && !wready; n++) begin
            step();
            if (d_accept) d_req = 1'b0;
        end
        d_req = 1'b0;
        chk("rst_mid_reached_wdata", {31'd0, wready}, 32'd1);
        rst = 1'b1;
        step();
        chk_all_zero("rst_mid");
        rst = 1'b0;
        step(); step();
        run_d(1'b1, 32'h40, 32'h0BADF00D, acc_c, fin_c, was_err);
        chk("fresh_write_done_cycle", fin_c, 32'd4);
        step();
        run_d(1'b0, 32'h40, 32'h0, acc_c, fin_c, was_err);
        chk("fresh_read_data", d_rdata, 32'h0BADF00D);
        step(); step();

        // One write was aborted by reset; every other accept closed with done or error.
        chk("accept_balance", acc_total, fin_total + 1);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

endmodule
